mac_accum: RTL and testbench
============================

# mac_accum

Signed multiply-accumulate back end that sits directly downstream of the 8×8 signed multiplier. Each cycle it can consume one 16-bit signed product over a valid/ready handshake and sign-extend it into an ACC_W-bit accumulator. It closes a frame on the beat marked `in_last` and then holds the frame sum, beat count and overflow flag on a valid/ready output port until they are taken. Typical use is dot products and FIR taps built from back-to-back multiplier results.

## Interface
Parameters:
- `ACC_W`, 24, accumulator and result width in bits; legal range 16..32.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_valid`  input  1  `in_prod` and `in_last` are valid this cycle.
- `in_ready`  output  1  block accepts a beat this cycle.
- `in_prod`  input  16  signed product from the multiplier.
- `in_last`  input  1  this beat closes the current frame.
- `out_valid`  output  1  frame result is available.
- `out_ready`  input  1  consumer takes the result this cycle.
- `out_sum`  output  ACC_W  signed frame sum.
- `out_count`  output  8  number of beats in the frame, saturating at 255.
- `out_ovf`  output  1  at least one accumulate step in the frame overflowed ACC_W.

## Operation
- States:
  - IDLE: no beats accepted yet in this frame.
  - ACCUM: at least one beat accepted, no `in_last` yet.
  - HOLD: result presented on the output port.
- Accept: a beat is accepted when `in_valid && in_ready`. `in_ready` is 1 in IDLE and ACCUM and 0 in HOLD.
- On each accepted beat:
  - `acc <= acc + sext(in_prod)`.
  - `cnt <= (cnt == 255) ? 255 : cnt + 1`.
  - `ovf <= ovf | step_overflow`.
- Step overflow: operands share a sign and the ACC_W-bit result has the opposite sign.
- Transitions:
  - IDLE → ACCUM on an accepted beat with `in_last = 0`.
  - ACCUM → ACCUM on further accepted beats with `in_last = 0`.
  - IDLE or ACCUM → HOLD on an accepted beat with `in_last = 1`. The updated acc, cnt and ovf values are registered into `out_sum`, `out_count` and `out_ovf`, and `out_valid` is set.
  - HOLD → IDLE when `out_valid && out_ready`. acc, cnt and ovf clear to 0 and `out_valid` falls.
- Output stability: in HOLD, `out_sum`, `out_count` and `out_ovf` are stable until the handshake. In IDLE and ACCUM they keep the last frame's values.
- `in_valid` low leaves all state unchanged, including mid-frame.
- A single-beat frame (`in_last` on the first beat) is legal: `out_sum = sext(in_prod)`, `out_count = 1`.

## Timing
- Reset values: `out_valid = 0`, `out_sum = 0`, `out_count = 0`, `out_ovf = 0`, `in_ready = 1`. State is IDLE, acc, cnt and ovf are 0.
- Reset mid-frame discards the partial sum.
- Latency: `out_valid` rises on the clock edge that accepts the `in_last` beat, so the result is visible the next cycle.
- Throughput: one beat per cycle within a frame, plus at least one idle input cycle per frame (the HOLD cycle).
- `in_ready` re-asserts the cycle after the output handshake.
- `in_ready` depends only on state; it has no combinational path from `out_ready`.
- Accumulation is a single registered add. No output is a combinational function of any input.

## Configuration
- `MAC_ACCUM_SAT_EN` defined: an overflowing step clamps acc to +(2^(ACC_W-1))-1 or -(2^(ACC_W-1)) according to the operand sign, and sets ovf.
- `MAC_ACCUM_SAT_EN` undefined: acc wraps modulo 2^ACC_W, and ovf is still set on every overflowing step.
- In both builds ovf is sticky for the frame.

## Test plan
- Basic frame: ACC_W=24, beats 100, -50, 16384, -1 with `in_last` on the fourth beat, `out_ready=1` → one cycle later `out_valid=1`, `out_sum=16433`, `out_count=4`, `out_ovf=0`. `in_ready=0` for exactly one cycle.
- Single-beat frame: beat -32768 with `in_last` → `out_sum=-32768`, `out_count=1`.
- Overflow, ACC_W=16: beats 16384, 16384 (last).
  - With `MAC_ACCUM_SAT_EN`: `out_sum=32767`, `out_ovf=1`.
  - Without it: `out_sum=-32768`, `out_ovf=1`.
- Backpressure: hold `out_ready=0` for 3 cycles after the result → `out_sum`, `out_count` and `out_valid` stable and `in_ready=0` throughout. The next frame starts cleanly after the handshake.
- Input gaps and reset:
  - Frame 5, gap, 5, gap, 5 (last) with `in_valid` dropped between beats → `out_sum=15`, `out_count=3`.
  - Assert `rst_n` after two beats → all outputs 0; the following frame 7 (last) gives `out_sum=7`.
- Count saturation: 300-beat frame of value 1 with ACC_W=24 → `out_sum=300`, `out_count=255`.

Source files
------------

// File: rtl/mac_accum.sv
// Signed multiply-accumulate back end: sums 16-bit products into an ACC_W-bit frame total.
// Optional build macro MAC_ACCUM_SAT_EN clamps overflowing steps instead of wrapping.
module mac_accum #(
  parameter int unsigned ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [7:0]       out_count,
  output logic             out_ovf
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef MAC_ACCUM_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_sum_q;
  logic [CNT_W-1:0] out_count_q;
  logic             out_ovf_q;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum_raw;
  logic             step_ovf;
  logic             accept;

  // Next accumulator values for the beat currently on the input port
  always_comb begin
    prod_ext = ACC_W'($signed(in_prod));
    sum_raw  = acc_q + prod_ext;
    step_ovf = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
               (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef MAC_ACCUM_SAT_EN
    acc_d    = step_ovf ? (prod_ext[ACC_W-1] ? SAT_MIN : SAT_MAX) : sum_raw;
`else
    acc_d    = sum_raw;
`endif
    cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    ovf_d    = ovf_q | step_ovf;
    accept   = in_valid && in_ready_q;
  end

  // Frame state machine; in_ready is kept as its own flop so it never sees out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (in_last) begin
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_sum_q   <= acc_d;
              out_count_q <= cnt_d;
              out_ovf_q   <= ovf_d;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mac_accum.sv
// Bench for mac_accum: two instances (ACC_W=24 and ACC_W=16) fed the same beats,
// checked every cycle against an integer frame model plus hand-computed frame results.
module tb_mac_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_prod = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic               rdy_a, val_a, ovf_a;
  logic signed [23:0] sum_a;
  logic [7:0]         cnt_a;
  logic               rdy_b, val_b, ovf_b;
  logic signed [15:0] sum_b;
  logic [7:0]         cnt_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mac_accum #(.ACC_W(24)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
    .in_prod(in_prod), .in_last(in_last), .out_valid(val_a), .out_ready(out_ready),
    .out_sum(sum_a), .out_count(cnt_a), .out_ovf(ovf_a)
  );

  mac_accum #(.ACC_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
    .in_prod(in_prod), .in_last(in_last), .out_valid(val_b), .out_ready(out_ready),
    .out_sum(sum_b), .out_count(cnt_b), .out_ovf(ovf_b)
  );

  // Frame-level model: exact integer sums, range-checked against each width
  int    mw [2] = '{24, 16};
  bit    m_hold [2];
  longint m_acc [2];
  int    m_cnt [2];
  bit    m_ovf [2];
  longint m_sum [2];
  int    m_ocnt [2];
  bit    m_oovf [2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      longint hi, lo, t;
      hi = (longint'(1) <<< (mw[k] - 1)) - 1;
      lo = -(longint'(1) <<< (mw[k] - 1));
      if (!rst_n) begin
        m_hold[k] = 0; m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
        m_sum[k] = 0; m_ocnt[k] = 0; m_oovf[k] = 0;
      end else if (m_hold[k]) begin
        if (out_ready) begin
          m_hold[k] = 0; m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
        end
      end else if (in_valid) begin
        t = m_acc[k] + longint'($signed(in_prod));
        if (t > hi || t < lo) begin
          m_ovf[k] = 1;
`ifdef MAC_ACCUM_SAT_EN
          t = (t > hi) ? hi : lo;
`else
          t = (t > hi) ? t - (longint'(1) <<< mw[k]) : t + (longint'(1) <<< mw[k]);
`endif
        end
        m_acc[k] = t;
        m_cnt[k] = m_cnt[k] + 1;
        if (in_last) begin
          m_hold[k] = 1;
          m_sum[k]  = m_acc[k];
          m_ocnt[k] = (m_cnt[k] > 255) ? 255 : m_cnt[k];
          m_oovf[k] = m_ovf[k];
        end
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    #1;
    check("a.in_ready",  longint'(rdy_a), longint'(!m_hold[0]));
    check("a.out_valid", longint'(val_a), longint'(m_hold[0]));
    check("a.out_sum",   longint'(sum_a), m_sum[0]);
    check("a.out_count", longint'(cnt_a), longint'(m_ocnt[0]));
    check("a.out_ovf",   longint'(ovf_a), longint'(m_oovf[0]));
    check("b.in_ready",  longint'(rdy_b), longint'(!m_hold[1]));
    check("b.out_valid", longint'(val_b), longint'(m_hold[1]));
    check("b.out_sum",   longint'(sum_b), m_sum[1]);
    check("b.out_count", longint'(cnt_b), longint'(m_ocnt[1]));
    check("b.out_ovf",   longint'(ovf_b), longint'(m_oovf[1]));
  end

  // Present one beat from a negedge and return at the negedge after it is taken
  task automatic send(input int p, input bit last);
    int n;
    n = 0;
    in_valid = 1'b1; in_prod = 16'(p); in_last = last;
    while (!(rdy_a && rdy_b) && n < 20) begin
      @(negedge clk); n++;
    end
    if (n >= 20) check("send_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int n;
    n = 0;
    while (!val_a && n < 50) begin
      @(negedge clk); n++;
    end
    if (n >= 50) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst.out_valid", longint'(val_a), 0);
    check("rst.in_ready",  longint'(rdy_a), 1);
    check("rst.out_sum",   longint'(sum_a), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame
    send(100, 0); send(-50, 0); send(16384, 0); send(-1, 1);
    wait_result("basic");
    check("basic.sum",   longint'(sum_a), 16433);
    check("basic.count", longint'(cnt_a), 4);
    check("basic.ovf",   longint'(ovf_a), 0);
    check("basic.ready_low", longint'(rdy_a), 0);
    @(negedge clk);
    check("basic.ready_back", longint'(rdy_a), 1);

    // Single-beat frame
    send(-32768, 1);
    wait_result("single");
    check("single.sum",   longint'(sum_a), -32768);
    check("single.count", longint'(cnt_a), 1);
    check("single.sum16", longint'(sum_b), -32768);

    // Overflow on the 16-bit instance
    send(16384, 0); send(16384, 1);
    wait_result("ovf");
`ifdef MAC_ACCUM_SAT_EN
    check("ovf.sum16", longint'(sum_b), 32767);
`else
    check("ovf.sum16", longint'(sum_b), -32768);
`endif
    check("ovf.ovf16", longint'(ovf_b), 1);
    check("ovf.sum24", longint'(sum_a), 32768);
    check("ovf.ovf24", longint'(ovf_a), 0);

    // Backpressure
    @(negedge clk);
    out_ready = 1'b0;
    send(7, 0); send(8, 1);
    for (int i = 0; i < 3; i++) begin
      check("bp.valid", longint'(val_a), 1);
      check("bp.ready", longint'(rdy_a), 0);
      check("bp.sum",   longint'(sum_a), 15);
      check("bp.count", longint'(cnt_a), 2);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.released", longint'(val_a), 0);
    send(3, 1);
    wait_result("bp_next");
    check("bp_next.sum",   longint'(sum_a), 3);
    check("bp_next.count", longint'(cnt_a), 1);

    // Input gaps
    send(5, 0); @(negedge clk); send(5, 0); repeat (2) @(negedge clk); send(5, 1);
    wait_result("gaps");
    check("gaps.sum",   longint'(sum_a), 15);
    check("gaps.count", longint'(cnt_a), 3);

    // Reset mid-frame
    send(40, 0); send(50, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst.sum",   longint'(sum_a), 0);
    check("mrst.count", longint'(cnt_a), 0);
    check("mrst.valid", longint'(val_a), 0);
    check("mrst.ready", longint'(rdy_a), 1);
    rst_n = 1'b1;
    @(negedge clk);
    send(7, 1);
    wait_result("mrst_next");
    check("mrst_next.sum",   longint'(sum_a), 7);
    check("mrst_next.count", longint'(cnt_a), 1);

    // Count saturation
    for (int i = 0; i < 300; i++) send(1, (i == 299));
    wait_result("sat");
    check("sat.sum",   longint'(sum_a), 300);
    check("sat.count", longint'(cnt_a), 255);
    check("sat.ovf",   longint'(ovf_a), 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
